// File: rtl/keypad_debounce_if.sv
// Signal bundle between the keypad scanner side and the debounced key-code consumer.
// The master drives the raw scan sample; the slave (the debouncer) returns the accepted key state.
interface keypad_debounce_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       press;
    logic [3:0] key;
    logic       new_key;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       held;

    modport master (
        output rows, cols, press,
        input  key, new_key, digit0, digit1, held
    );

    modport slave (
        input  rows, cols, press,
        output key, new_key, digit0, digit1, held
    );
endinterface

// File: rtl/keypad_debounce.sv
// Debounces the keypad scan sample into one registered hex key code per press,
// keeping the last two accepted keys as a two-digit history.
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_debounce_if.slave  kp
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_q, key_d;
    logic [3:0]    digit0_q, digit0_d;
    logic [3:0]    digit1_q, digit1_d;
    logic          newKey_q, newKey_d;
    logic          held_q, held_d;

    logic          sampleValid;
    logic [3:0]    sampleCode;

    function automatic logic isOneHot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] bitIndex(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Keypad legend: rows of 1-2-3-A, 4-5-6-B, 7-8-9-C, E-0-F-D
    function automatic logic [3:0] keyCode(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

    assign sampleValid = kp.press && isOneHot(kp.rows) && isOneHot(kp.cols);
    assign sampleCode  = keyCode(bitIndex(kp.rows), bitIndex(kp.cols));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= 4'd0;
            key_q    <= 4'd0;
            digit0_q <= 4'd0;
            digit1_q <= 4'd0;
            newKey_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            key_q    <= key_d;
            digit0_q <= digit0_d;
            digit1_q <= digit1_d;
            newKey_q <= newKey_d;
            held_q   <= held_d;
        end
    end

    // The same counter times both press acceptance and release; the states never overlap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        key_d    = key_q;
        digit0_d = digit0_q;
        digit1_d = digit1_q;
        newKey_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sampleValid) begin
                    cand_d  = sampleCode;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sampleValid && (sampleCode == cand_q)) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = HELD;
                        key_d    = cand_q;
                        digit0_d = cand_q;
                        digit1_d = digit0_q;
                        newKey_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!sampleValid) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sampleValid) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        held_d = (state_d == HELD) || (state_d == RELEASE);
    end

    assign kp.key     = key_q;
    assign kp.new_key = newKey_q;
    assign kp.digit0  = digit0_q;
    assign kp.digit1  = digit1_q;
    assign kp.held    = held_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Randomized and directed bench for keypad_debounce with a streak-counting reference model
// and a scoreboard that matches each new_key pulse against the expected key history.
module tb_keypad_debounce;

    localparam int N = 4;

    // Key legend by row*4+col, straight from the keypad face
    localparam logic [3:0] CODE_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef struct {
        logic [3:0] key;
        logic [3:0] d0;
        logic [3:0] d1;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_debounce_if kpIf ();

    keypad_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kpIf.slave)
    );

    int   checks = 0;
    int   passes = 0;
    exp_t expQ[$];

    bit         mHeld;
    int         streak;
    logic [3:0] streakCode;
    int         relRun;
    logic [3:0] mD0, mD1;

    task automatic compareVal(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        mHeld  = 1'b0;
        streak = 0;
        streakCode = 4'd0;
        relRun = 0;
        mD0    = 4'd0;
        mD1    = 4'd0;
        expQ.delete();
    endtask

    // A key is accepted after N agreeing valid samples; a code change discards the sample.
    task automatic modelStep(input logic [3:0] r, input logic [3:0] c, input logic p);
        bit         valid;
        int         ri, ci;
        logic [3:0] code;
        exp_t       e;
        valid = p && ($countones(r) == 1) && ($countones(c) == 1);
        ri = 0;
        ci = 0;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) ri = i;
            if (c[i]) ci = i;
        end
        code = CODE_MAP[ri*4 + ci];
        if (!mHeld) begin
            if (!valid) begin
                streak = 0;
            end else if (streak > 0 && code != streakCode) begin
                streak = 0;
            end else begin
                streak++;
                streakCode = code;
                if (streak == N) begin
                    mD1 = mD0;
                    mD0 = code;
                    e.key = code;
                    e.d0 = mD0;
                    e.d1 = mD1;
                    expQ.push_back(e);
                    mHeld  = 1'b1;
                    relRun = 0;
                    streak = 0;
                end
            end
        end else begin
            if (valid) begin
                relRun = 0;
            end else begin
                relRun++;
                if (relRun == N) begin
                    mHeld  = 1'b0;
                    streak = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input logic p);
        @(negedge clk);
        kpIf.rows  = r;
        kpIf.cols  = c;
        kpIf.press = p;
        @(posedge clk);
        if (reset) modelStep(r, c, p);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] k, input logic nk,
                               input logic [3:0] d0, input logic [3:0] d1, input logic h);
        #1;
        compareVal({tag, ".key"},     int'(kpIf.key),     int'(k));
        compareVal({tag, ".new_key"}, int'(kpIf.new_key), int'(nk));
        compareVal({tag, ".digit0"},  int'(kpIf.digit0),  int'(d0));
        compareVal({tag, ".digit1"},  int'(kpIf.digit1),  int'(d1));
        compareVal({tag, ".held"},    int'(kpIf.held),    int'(h));
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        #2;
        reset = 1'b0;
        modelReset();
        repeat (cycles) begin
            @(negedge clk);
            kpIf.rows  = 4'($urandom);
            kpIf.cols  = 4'($urandom);
            kpIf.press = 1'($urandom);
        end
        @(negedge clk);
        kpIf.press = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic repeatKey(input logic [3:0] r, input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) applyStimulus(r, c, 1'b1);
    endtask

    task automatic releaseFor(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 4'b0000, 1'b0);
    endtask

    // Scoreboard monitor: every pulse must match the next expected key record.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            compareVal("reset_outputs",
                       int'({kpIf.key, kpIf.new_key, kpIf.digit0, kpIf.digit1, kpIf.held}), 0);
        end else begin
            compareVal("held", int'(kpIf.held), int'(mHeld));
            compareVal("pulse", int'(kpIf.new_key), int'(expQ.size() != 0));
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                if (kpIf.new_key) begin
                    compareVal("sb.key",    int'(kpIf.key),    int'(e.key));
                    compareVal("sb.digit0", int'(kpIf.digit0), int'(e.d0));
                    compareVal("sb.digit1", int'(kpIf.digit1), int'(e.d1));
                end
            end
        end
    end

    initial begin
        logic [3:0] r, c, nr, nc;
        logic [3:0] pattern [11];
        reset      = 1'b0;
        kpIf.rows  = 4'd0;
        kpIf.cols  = 4'd0;
        kpIf.press = 1'b0;
        modelReset();

        repeat (3) begin
            @(negedge clk);
            kpIf.rows  = 4'($urandom);
            kpIf.cols  = 4'($urandom);
            kpIf.press = 1'($urandom);
        end
        @(negedge clk);
        kpIf.press = 1'b0;
        #2;
        reset = 1'b1;
        checkOutput("reset_release", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

        repeatKey(4'b0010, 4'b0010, 2);
        doReset(2);
        checkOutput("reset_mid_debounce", 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        releaseFor(2);

        repeatKey(4'b0010, 4'b0010, 10);
        checkOutput("clean_press", 4'h5, 1'b0, 4'h5, 4'h0, 1'b1);
        releaseFor(3);
        checkOutput("release_partial", 4'h5, 1'b0, 4'h5, 4'h0, 1'b1);
        releaseFor(1);
        checkOutput("release_done", 4'h5, 1'b0, 4'h5, 4'h0, 1'b0);

        repeatKey(4'b0001, 4'b1000, 6);
        checkOutput("second_key", 4'hA, 1'b0, 4'hA, 4'h5, 1'b1);
        releaseFor(4);

        repeatKey(4'b0010, 4'b0010, 5);
        releaseFor(2);
        repeatKey(4'b0100, 4'b0100, 5);
        checkOutput("release_glitch", 4'h5, 1'b0, 4'h5, 4'hA, 1'b1);
        releaseFor(4);

        pattern = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 11; i++) applyStimulus(4'b0010, 4'b0010, pattern[i][0]);
        checkOutput("bounce_pulse", 4'h5, 1'b1, 4'h5, 4'h5, 1'b1);
        releaseFor(4);

        for (int i = 0; i < 8; i++) applyStimulus(4'b0010, 4'b0110, 1'b1);
        checkOutput("multi_col", 4'h5, 1'b0, 4'h5, 4'h5, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(4'b0000, 4'b0010, 1'b1);
        checkOutput("no_row", 4'h5, 1'b0, 4'h5, 4'h5, 1'b0);

        for (int seg = 0; seg < 80; seg++) begin
            r = 4'b0001 << $urandom_range(0, 3);
            c = 4'b0001 << $urandom_range(0, 3);
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                case ($urandom_range(0, 9))
                    0: applyStimulus(r, c, 1'b0);
                    1: applyStimulus(r, c | (4'b0001 << $urandom_range(0, 3)), 1'b1);
                    2: applyStimulus(4'b0000, c, 1'b1);
                    3: begin
                        nr = 4'b0001 << $urandom_range(0, 3);
                        nc = 4'b0001 << $urandom_range(0, 3);
                        applyStimulus(nr, nc, 1'b1);
                    end
                    default: applyStimulus(r, c, 1'b1);
                endcase
            end
            releaseFor($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) doReset(2);
        end

        releaseFor(N + 2);
        compareVal("queue_drained", expQ.size(), 0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_debounce.md
# keypad_debounce

Debounces and decodes the scan result from `keypad_input` into a single registered hexadecimal key code. It sits directly downstream of `keypad_input` and upstream of the dual seven-segment display logic. Each key press produces exactly one `new_key` pulse, however much the contacts bounce. The block keeps a two-digit history: the most recent key in `digit0` and the previous key in `digit1`.

## Interface
- `DEBOUNCE_CYCLES`, default 50000. Number of consecutive agreeing samples needed to accept a press or a release. Must be at least 2. The counter is `$clog2(DEBOUNCE_CYCLES)+1` bits wide.
- `clk`  in  1  system clock. This is the single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `rows`  in  4  one-hot row currently driven by `keypad_input`, active-high.
- `cols`  in  4  synchronized column sample from `keypad_input`, active-high.
- `press`  in  1  from `keypad_input`. High while some key is detected on the current row.
- `key`  out  4  code of the last accepted key.
- `new_key`  out  1  one-cycle pulse when a key is accepted.
- `digit0`  out  4  most recent accepted key.
- `digit1`  out  4  previous accepted key.
- `held`  out  1  high while an accepted key is still considered down.

## Operation
- **Valid sample.** A cycle is a valid sample when `press`=1 and `rows` is one-hot and `cols` is one-hot. All other combinations, including multiple columns, are treated as no press.
- **Index decode.** Row index `r` is the set bit of `rows`. Column index `c` is the set bit of `cols`.
- **Code map:**
  - r0: c0..c3 map to 1, 2, 3, A.
  - r1: c0..c3 map to 4, 5, 6, B.
  - r2: c0..c3 map to 7, 8, 9, C.
  - r3: c0..c3 map to E, 0, F, D.
- **FSM states.** The FSM has four states: IDLE, DEBOUNCE, HELD and RELEASE. Counter `cnt` and candidate code `cand` are registers.
- **IDLE**
  - On a valid sample: set `cand` to the decoded code, set `cnt` to 1, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- **DEBOUNCE**
  - Valid sample with code equal to `cand` and `cnt`=DEBOUNCE_CYCLES-1: go to HELD. On the same edge, load `key` and `digit0` with `cand`, load `digit1` with the old `digit0`, and set `new_key` to 1.
  - Valid sample with the same code, count not reached: increment `cnt`.
  - Invalid sample, or a different code: go to IDLE with no output change.
- **HELD**
  - Any valid sample (any code): stay in HELD. A second key is never registered while one is held.
  - Invalid sample: set `cnt` to 1, go to RELEASE.
- **RELEASE**
  - Any valid sample: return to HELD with no new pulse.
  - Invalid sample with `cnt`=DEBOUNCE_CYCLES-1: go to IDLE.
  - Invalid sample, count not reached: increment `cnt`.
- **`held` output.** `held` is high in the HELD and RELEASE states.
- **Reset.** Asserting `reset` at any time, including mid-debounce or while held, forces:
  - state to IDLE;
  - `cnt`, `cand`, `key`, `digit0` and `digit1` to 0;
  - `new_key` and `held` to 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Press latency.** N = DEBOUNCE_CYCLES. If valid samples of one code occur at edges k through k+N-1, then `new_key`=1 in the cycle following edge k+N-1. `key`, `digit0`, `digit1` and `held` update on that same edge.
- **Pulse width.** `new_key` is high for exactly one cycle and is cleared on the next edge.
- **Release latency.** N consecutive invalid samples return the FSM to IDLE. A fresh press can then be accepted no sooner than N further cycles.
- **Bounce during press.** Any invalid sample in DEBOUNCE restarts acceptance from IDLE. The earliest acceptance is N cycles after the next valid sample.
- **Simultaneous events.** A code change in DEBOUNCE is treated as invalid: the FSM returns to IDLE, and the new code is picked up on the following valid sample.
- **Counter saturation.** `cnt` never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
1. **Reset.** Hold `reset`=0 with random inputs, then release → all outputs 0. Assert `reset` mid-DEBOUNCE → state returns to IDLE with outputs 0, and no `new_key` pulse occurs.
2. **Clean press.** `rows`=0010, `cols`=0010, `press`=1 for 10 cycles → a single `new_key` pulse after the 4th sample; `key`=5, `digit0`=5, `digit1`=0, `held`=1 until 4 cycles after `press` drops.
3. **Press bounce.** Press '5' with `press` pattern 1,1,0,1,1,1,0,1,1,1,1 → no pulse until the final four consecutive 1s, then exactly one pulse with `key`=5.
4. **Second key.** After scenario 2 and a 4-cycle release, press `rows`=0001, `cols`=1000 for 6 cycles → one pulse; `key`=A, `digit0`=A, `digit1`=5.
5. **Release glitch.** While '5' is held, drop `press` for 2 cycles, then return to '9' (`rows`=0100, `cols`=0100) → no pulse, `held` stays 1, `digits` unchanged.
6. **Invalid inputs.** `press`=1 with `cols`=0110 for 8 cycles → no pulse. `press`=1 with `rows`=0000 for 8 cycles → no pulse, `held`=0.
